// File: rtl/ahblite_db_regbank.sv
// AHB-Lite debug register bank: NREGS byte-lane-writable registers plus a 32-bit trace FIFO.
// Define DB_REGBANK_WAIT_EN to stall (HREADYOUT low) on a push into a full FIFO instead of dropping it.
module ahblite_db_regbank #(
  parameter int NREGS  = 4,
  parameter int RW     = 8,
  parameter int FDEPTH = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [23:0]           HADDR,
  input  logic                  HREADY,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [NREGS*RW-1:0]   db_reg,
  output logic [31:0]           trc_data,
  output logic                  trc_valid,
  input  logic                  trc_ready
);

  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  // address phase capture
  logic        r_sel, r_write, r_trans1;
  logic [23:0] r_addr;
  logic [2:0]  r_size;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel    <= 1'b0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_size   <= '0;
      r_trans1 <= 1'b0;
    end else if (HREADY) begin
      r_sel    <= HSEL & HREADY;
      r_addr   <= HADDR;
      r_write  <= HWRITE;
      r_size   <= HSIZE;
      r_trans1 <= HTRANS[1];
    end
  end

  logic       w_dphase, w_wr, w_hi_ok, w_push_hit, w_stat_hit;
  logic [5:0] w_word;
  logic       w_unused;

  assign w_dphase   = r_sel & r_trans1;
  assign w_wr       = w_dphase & r_write;
  assign w_hi_ok    = (r_addr[23:8] == 16'd0);
  assign w_word     = r_addr[7:2];
  assign w_push_hit = w_hi_ok & (w_word == 6'h10);
  assign w_stat_hit = w_hi_ok & (w_word == 6'h11);
  assign w_unused   = HTRANS[0];

  // byte lanes enabled by the registered size/address
  logic [3:0] w_lane;
  always_comb begin
    w_lane = 4'b0000;
    case (r_size)
      3'd0:    w_lane = 4'b0001 << r_addr[1:0];
      3'd1:    w_lane = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_lane = 4'b1111;
    endcase
  end

  logic [RW-1:0]    w_rmask;
  logic [NREGS-1:0] w_reg_we;

  for (genvar b = 0; b < RW; b++) begin : g_mask
    assign w_rmask[b] = w_lane[b/8];
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_we
    assign w_reg_we[g] = w_wr & w_hi_ok & (w_word == 6'(g));
  end

  logic [NREGS-1:0][RW-1:0] r_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_reg <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (w_reg_we[i])
          r_reg[i] <= (r_reg[i] & ~w_rmask) | (HWDATA[RW-1:0] & w_rmask);
    end
  end

  assign db_reg = r_reg;

  // trace FIFO
  logic [31:0]   r_mem [FDEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_empty, w_full, w_pop, w_push_req, w_push, w_stall, w_ovf_set, w_ovf_clr;
  logic [31:0]   w_pdata;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FDEPTH));
  assign w_pop      = ~w_empty & trc_ready;
  assign w_push_req = w_wr & w_push_hit;
  assign w_ovf_clr  = w_wr & w_stat_hit & HWDATA[16];

`ifdef DB_REGBANK_WAIT_EN
  logic        r_stall;
  logic [31:0] r_hold;

  assign w_stall   = w_push_req & w_full & ~w_pop;
  assign w_push    = w_push_req & ~w_stall;
  assign w_ovf_set = 1'b0;
  // keep the first-cycle write data so the push completes with it even if HWDATA moves
  assign w_pdata   = r_stall ? r_hold : HWDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stall <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_stall <= w_stall;
      if (w_stall && !r_stall) r_hold <= HWDATA;
    end
  end
`else
  assign w_stall   = 1'b0;
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;
  assign w_pdata   = HWDATA;
`endif

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr] <= w_pdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // a new overflow takes priority over a software clear in the same cycle
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign trc_valid = ~w_empty;
  assign trc_data  = r_mem[r_rptr];

  // read mux, driven from the registered address
  logic [31:0] w_status, w_rdata;
  assign w_status = {15'd0, r_ovf, 6'd0, w_full, w_empty, 8'(r_count)};

  always_comb begin
    w_rdata = 32'hDEADBEEF;
    if (w_hi_ok) begin
      if (w_word == 6'h10)      w_rdata = 32'd0;
      else if (w_word == 6'h11) w_rdata = w_status;
      for (int i = 0; i < NREGS; i++)
        if (w_word == 6'(i)) w_rdata = 32'(r_reg[i]);
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = ~w_stall;
  assign HRESP     = 2'b00;

endmodule

// File: tb/tb_ahblite_db_regbank.sv
// Randomized scoreboard bench for ahblite_db_regbank (NREGS=4, RW=16, FDEPTH=8).
module tb_ahblite_db_regbank;
  localparam int NREGS = 4, RW = 16, FDEPTH = 8;

  logic HCLK = 1'b0, HRESETn, HSEL, HREADY, HWRITE, HREADYOUT, trc_valid, trc_ready;
  logic [23:0] HADDR;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA, HRDATA, trc_data;
  logic [NREGS*RW-1:0] db_reg;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahblite_db_regbank #(.NREGS(NREGS), .RW(RW), .FDEPTH(FDEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HREADY(HREADY),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .db_reg(db_reg), .trc_data(trc_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready));

  int checks = 0, errors = 0;

  // reference model
  logic [RW-1:0] m_reg [NREGS];
  logic [31:0]   m_q[$];
  logic          m_ovf;
  logic [31:0]   exp_q[$];
  logic [31:0]   pend;
  logic          dp_read;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {15'd0, m_ovf, 6'd0, 1'(m_q.size() == FDEPTH), 1'(m_q.size() == 0), 8'(m_q.size())};
  endfunction

  function automatic logic [31:0] m_read(input logic [23:0] a);
    int w = int'(a[7:2]);
    if (a[23:8] != 16'd0) return 32'hDEADBEEF;
    if (w < NREGS) return 32'(m_reg[w]);
    if (w == 16)   return 32'd0;
    if (w == 17)   return m_status();
    return 32'hDEADBEEF;
  endfunction

  function automatic void m_write(input logic [23:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w = int'(a[7:2]);
    if (a[23:8] != 16'd0) return;
    if (w < NREGS) begin
      for (int j = 0; j < RW; j++) begin
        int lane = j / 8;
        bit en;
        if (sz == 0)      en = (lane == int'(a[1:0]));
        else if (sz == 1) en = ((lane / 2) == int'(a[1]));
        else              en = 1'b1;
        if (en) m_reg[w][j] = d[j];
      end
    end else if (w == 16) begin
      if (m_q.size() < FDEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (w == 17) begin
      if (d[16]) m_ovf = 1'b0;
    end
  endfunction

  // one pipelined AHB beat: address phase of this transfer, data of the previous one
  task automatic bus(input logic act, input logic w, input logic [23:0] a,
                     input logic [2:0] sz, input logic [31:0] d);
    int n = 0;
    logic rdy;
    HSEL = act; HTRANS = act ? 2'b10 : 2'b00; HADDR = a; HWRITE = w; HSIZE = sz; HWDATA = pend;
    do begin
      @(negedge HCLK); rdy = HREADYOUT;
      @(posedge HCLK); #1; n++;
    end while (!rdy && n < 64);
    if (!rdy) chk("bus_timeout", 32'(rdy), 32'd1);
    pend = d;
    dp_read = act & ~w;
    if (act) begin
      if (w) m_write(a, sz, d);
      else   exp_q.push_back(m_read(a));
    end
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 24'h0, 3'd0, 32'h0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      trc_ready = 1'b1;
      @(negedge HCLK);
      if (m_q.size() > 0) begin
        chk("trc_valid", 32'(trc_valid), 32'd1);
        chk("trc_data", trc_data, m_q[0]);
        void'(m_q.pop_front());
      end else begin
        chk("trc_valid_empty", 32'(trc_valid), 32'd0);
      end
      @(posedge HCLK); #1;
    end
    trc_ready = 1'b0;
  endtask

  task automatic chk_regs();
    for (int i = 0; i < NREGS; i++) chk("db_reg", 32'(db_reg[i*RW +: RW]), 32'(m_reg[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_q.delete(); m_ovf = 1'b0; pend = '0; dp_read = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = '0; HWDATA = '0;
    trc_ready = 1'b0;
  endtask

  // scoreboard monitor: every completed read data phase is compared against the queue
  always @(negedge HCLK) begin
    if (HRESETn && dp_read && HREADYOUT) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow actual=%h expected=none", HRDATA);
      end else begin
        chk("rdata", HRDATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] a;
    logic [31:0] d;
    int op, w;
    HRESETn = 1'b0;
    model_reset();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;

    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_trc_valid", 32'(trc_valid), 32'd0);
    chk("hresp", 32'(HRESP), 32'd0);
    chk_regs();
    bus(1, 0, 24'h00, 3'd2, 0);
    bus(1, 0, 24'h44, 3'd2, 0);

    // word write then single byte lane, back-to-back readback
    bus(1, 1, 24'h04, 3'd2, 32'hA5A5_1234);
    bus(1, 1, 24'h05, 3'd0, 32'h0000_FF00);
    bus(1, 0, 24'h04, 3'd2, 0);
    idle();
    chk("reg1_bytewrite", 32'(db_reg[31:16]), 32'h0000_FF34);

    // two pushes, status, then pop both
    bus(1, 1, 24'h40, 3'd2, 32'h11);
    bus(1, 1, 24'h40, 3'd2, 32'h22);
    bus(1, 0, 24'h44, 3'd2, 0);
    idle();
    chk("fifo_head", trc_data, 32'h11);
    pop_n(2);
    chk("fifo_drained", 32'(trc_valid), 32'd0);

    // unmapped space
    bus(1, 0, 24'h80, 3'd2, 0);
    bus(1, 0, 24'h001004, 3'd2, 0);
    bus(1, 1, 24'h80, 3'd2, 32'h1234_5678);
    bus(1, 1, 24'h000104, 3'd2, 32'h9999_9999);
    bus(1, 0, 24'h04, 3'd2, 0);
    idle();
    chk_regs();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 9);
      w = $urandom_range(0, NREGS - 1);
      a = {16'h0, 6'(w), 2'($urandom_range(0, 3))};
      d = $urandom;
      case (op)
        0, 1, 2: bus(1, 1, a, 3'($urandom_range(0, 2)), d);
        3:       bus(1, 0, a, 3'd2, 0);
        4: begin
`ifdef DB_REGBANK_WAIT_EN
          if (m_q.size() < FDEPTH) bus(1, 1, 24'h40, 3'($urandom_range(0, 2)), d);
`else
          bus(1, 1, 24'h40, 3'($urandom_range(0, 2)), d);
`endif
        end
        5: bus(1, 0, 24'h44, 3'd2, 0);
        6: begin idle(); chk_regs(); pop_n($urandom_range(1, 3)); end
        7: begin
          w = $urandom_range(4, 63);
          if (w == 16 || w == 17) w = 20;
          bus(1, 1'($urandom_range(0, 1)), {16'h0, 6'(w), 2'b00}, 3'd2, d);
        end
        8: bus(1, 1, 24'h44, 3'd2, d);
        default: bus(1, 0, {8'($urandom_range(1, 255)), 16'h0004}, 3'd2, 0);
      endcase
    end

    idle();
    pop_n(FDEPTH + 1);
    bus(1, 1, 24'h44, 3'd2, 32'h0001_0000);
    bus(1, 0, 24'h44, 3'd2, 0);
    idle();

`ifndef DB_REGBANK_WAIT_EN
    // overflow: nine pushes into an eight-deep FIFO, then clear ovf
    for (int i = 0; i < 9; i++) bus(1, 1, 24'h40, 3'd2, 32'h100 + i);
    bus(1, 0, 24'h44, 3'd2, 0);
    bus(1, 1, 24'h44, 3'd2, 32'h0001_0000);
    bus(1, 0, 24'h44, 3'd2, 0);
    idle();
    chk("ovf_no_stall", 32'(HREADYOUT), 32'd1);
    HRESETn = 1'b0; #1;
    chk("rst_async_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_async_trc_valid", 32'(trc_valid), 32'd0);
`else
    // stall on full, released by a single pop
    for (int i = 0; i < FDEPTH; i++) bus(1, 1, 24'h40, 3'd2, 32'h200 + i);
    bus(1, 0, 24'h44, 3'd2, 0);
    HSEL = 1; HTRANS = 2'b10; HADDR = 24'h40; HWRITE = 1; HSIZE = 3'd2; HWDATA = pend;
    @(negedge HCLK); @(posedge HCLK); #1;
    dp_read = 1'b0; pend = '0;
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h0000_CAFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK); chk("stall_hreadyout", 32'(HREADYOUT), 32'd0);
      @(posedge HCLK); #1;
    end
    trc_ready = 1'b1;
    @(negedge HCLK);
    chk("release_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("release_pop_data", trc_data, m_q[0]);
    @(posedge HCLK); #1;
    trc_ready = 1'b0;
    void'(m_q.pop_front());
    m_q.push_back(32'h0000_CAFE);
    bus(1, 0, 24'h44, 3'd2, 0);
    idle();
    pop_n(FDEPTH - 1);
    chk("last_entry", trc_data, 32'h0000_CAFE);
    pop_n(1);
    // refill and reset in the middle of a stalled push
    for (int i = 0; i < FDEPTH; i++) bus(1, 1, 24'h40, 3'd2, 32'h300 + i);
    HSEL = 1; HTRANS = 2'b10; HADDR = 24'h40; HWRITE = 1; HSIZE = 3'd2; HWDATA = pend;
    @(negedge HCLK); @(posedge HCLK); #1;
    dp_read = 1'b0;
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h0000_BEEF;
    @(negedge HCLK); chk("stall_before_reset", 32'(HREADYOUT), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0; #1;
    chk("rst_async_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_async_trc_valid", 32'(trc_valid), 32'd0);
`endif

    model_reset();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    bus(1, 0, 24'h44, 3'd2, 0);
    bus(1, 0, 24'h04, 3'd2, 0);
    idle();
    chk_regs();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
